// File: rtl/sram_fault_model_pkg.sv
// Shared definitions for the fault-injecting SRAM model: geometry, fault codes and the
// layout of one fault table entry.
package sram_fault_model_pkg;

    localparam int DW         = 4;
    localparam int AW         = 8;
    localparam int NUM_FAULTS = 4;
    localparam int HIT_W      = 16;
    localparam int IDX_W      = $clog2(NUM_FAULTS);
    localparam int BIT_W      = $clog2(DW);
    localparam int DEPTH      = 1 << AW;

    // Codes 5-7 are reserved and decode to "no fault".
    typedef enum logic [2:0] {
        FT_SA0    = 3'd0,
        FT_SA1    = 3'd1,
        FT_TF_UP  = 3'd2,
        FT_TF_DN  = 3'd3,
        FT_CF_INV = 3'd4,
        FT_RSV5   = 3'd5,
        FT_RSV6   = 3'd6,
        FT_RSV7   = 3'd7
    } faultType_e;

    typedef struct packed {
        logic                 en;
        faultType_e           ftype;
        logic [AW-1:0]        faultAddr;
        logic [BIT_W-1:0]     faultBit;
        logic [AW-1:0]        aggrAddr;
        logic [BIT_W-1:0]     aggrBit;
    } faultEntry_t;

    function automatic logic [DW-1:0] bitMask(input logic [BIT_W-1:0] b);
        bitMask    = '0;
        bitMask[b] = 1'b1;
    endfunction

endpackage

// File: rtl/sram_fault_model_if.sv
// Access and fault-table port of the SRAM fault model; the BIST engine or bench is the master.
interface sram_fault_model_if;
    import sram_fault_model_pkg::*;

    logic [DW-1:0]    dat_in;
    logic [AW-1:0]    addr_in;
    logic             w_en;
    logic [DW-1:0]    read_d;

    logic             fault_load;
    logic [IDX_W-1:0] fault_idx;
    logic             fault_en;
    logic [2:0]       fault_type;
    logic [AW-1:0]    fault_addr;
    logic [BIT_W-1:0] fault_bit;
    logic [AW-1:0]    aggr_addr;
    logic [BIT_W-1:0] aggr_bit;

    logic [HIT_W-1:0] fault_hits;

    modport master (
        output dat_in, addr_in, w_en,
        output fault_load, fault_idx, fault_en, fault_type,
        output fault_addr, fault_bit, aggr_addr, aggr_bit,
        input  read_d, fault_hits
    );

    modport slave (
        input  dat_in, addr_in, w_en,
        input  fault_load, fault_idx, fault_en, fault_type,
        input  fault_addr, fault_bit, aggr_addr, aggr_bit,
        output read_d, fault_hits
    );

endinterface

// File: rtl/sram_fault_model_entry.sv
// One fault table entry: holds its configuration and decodes per-bit masks against the
// current access address, plus the coupling-fault aggressor/victim description.
module sram_fault_model_entry
    import sram_fault_model_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  faultEntry_t      cfg_i,
    input  logic [AW-1:0]    accAddr_i,
    output logic [DW-1:0]    sa0Mask_o,
    output logic [DW-1:0]    sa1Mask_o,
    output logic [DW-1:0]    tfUpMask_o,
    output logic [DW-1:0]    tfDnMask_o,
    output logic             cfAggrHit_o,
    output logic [BIT_W-1:0] aggrBit_o,
    output logic [AW-1:0]    victimAddr_o,
    output logic [BIT_W-1:0] victimBit_o
);

    faultEntry_t entry_q;
    faultEntry_t entry_d;

    logic          victimHit;
    logic [DW-1:0] victimSel;

    always_comb begin
        entry_d = entry_q;
        if (load_i) begin
            entry_d = cfg_i;
        end
    end

    // A freshly loaded entry only becomes visible to accesses from the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    always_comb begin
        victimHit   = entry_q.en && (entry_q.faultAddr == accAddr_i);
        victimSel   = bitMask(entry_q.faultBit);
        sa0Mask_o   = '0;
        sa1Mask_o   = '0;
        tfUpMask_o  = '0;
        tfDnMask_o  = '0;
        cfAggrHit_o = 1'b0;
        case (entry_q.ftype)
            FT_SA0:    if (victimHit) sa0Mask_o  = victimSel;
            FT_SA1:    if (victimHit) sa1Mask_o  = victimSel;
            FT_TF_UP:  if (victimHit) tfUpMask_o = victimSel;
            FT_TF_DN:  if (victimHit) tfDnMask_o = victimSel;
            // A cell coupled to itself is meaningless, so such entries stay inert.
            FT_CF_INV: cfAggrHit_o = entry_q.en
                                     && (entry_q.aggrAddr == accAddr_i)
                                     && (entry_q.aggrAddr != entry_q.faultAddr);
            default:   ;
        endcase
    end

    assign aggrBit_o    = entry_q.aggrBit;
    assign victimAddr_o = entry_q.faultAddr;
    assign victimBit_o  = entry_q.faultBit;

endmodule

// File: rtl/sram_fault_model.sv
// 256x4 synchronous SRAM with a programmable fault table, used in place of the plain array
// under the MBIST engine so that march algorithms can be shown to catch real defects.
module sram_fault_model
    import sram_fault_model_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    sram_fault_model_if.slave  bus
);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    memD  [DEPTH];
    logic [DW-1:0]    readD_q;
    logic [DW-1:0]    readD_d;
    logic [HIT_W-1:0] faultHits_q;
    logic [HIT_W-1:0] faultHits_d;

    faultEntry_t      loadCfg;

    logic [DW-1:0]    sa0Mask    [NUM_FAULTS];
    logic [DW-1:0]    sa1Mask    [NUM_FAULTS];
    logic [DW-1:0]    tfUpMask   [NUM_FAULTS];
    logic [DW-1:0]    tfDnMask   [NUM_FAULTS];
    logic             cfAggrHit  [NUM_FAULTS];
    logic [BIT_W-1:0] aggrBit    [NUM_FAULTS];
    logic [AW-1:0]    victimAddr [NUM_FAULTS];
    logic [BIT_W-1:0] victimBit  [NUM_FAULTS];

    logic [DW-1:0]    sa0All;
    logic [DW-1:0]    sa1All;
    logic [DW-1:0]    tfUpAll;
    logic [DW-1:0]    tfDnAll;
    logic [DW-1:0]    oldWord;
    logic [DW-1:0]    wrWord;
    logic [DW-1:0]    rdMasked;
    logic             anyFlip;
    logic             hitNow;

    always_comb begin
        loadCfg.en        = bus.fault_en;
        loadCfg.ftype     = faultType_e'(bus.fault_type);
        loadCfg.faultAddr = bus.fault_addr;
        loadCfg.faultBit  = bus.fault_bit;
        loadCfg.aggrAddr  = bus.aggr_addr;
        loadCfg.aggrBit   = bus.aggr_bit;
    end

    for (genvar g = 0; g < NUM_FAULTS; g++) begin : gEntry
        sram_fault_model_entry uEntry (
            .clk          (clk),
            .rst          (rst),
            .load_i       (bus.fault_load && (bus.fault_idx == IDX_W'(g))),
            .cfg_i        (loadCfg),
            .accAddr_i    (bus.addr_in),
            .sa0Mask_o    (sa0Mask[g]),
            .sa1Mask_o    (sa1Mask[g]),
            .tfUpMask_o   (tfUpMask[g]),
            .tfDnMask_o   (tfDnMask[g]),
            .cfAggrHit_o  (cfAggrHit[g]),
            .aggrBit_o    (aggrBit[g]),
            .victimAddr_o (victimAddr[g]),
            .victimBit_o  (victimBit[g])
        );
    end

    // Write path: transition faults hold the old bit, stuck-at forces last so it dominates,
    // then coupling flips land on their victims (XOR, so repeated hits cancel pairwise).
    always_comb begin
        sa0All  = '0;
        sa1All  = '0;
        tfUpAll = '0;
        tfDnAll = '0;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            sa0All  = sa0All  | sa0Mask[i];
            sa1All  = sa1All  | sa1Mask[i];
            tfUpAll = tfUpAll | tfUpMask[i];
            tfDnAll = tfDnAll | tfDnMask[i];
        end

        oldWord = mem_q[bus.addr_in];
        wrWord  = bus.dat_in;
        wrWord  = wrWord & ~(tfUpAll & ~oldWord & bus.dat_in);
        wrWord  = wrWord |  (tfDnAll &  oldWord & ~bus.dat_in);
        wrWord  = (wrWord | sa1All) & ~sa0All;

        memD    = mem_q;
        anyFlip = 1'b0;
        if (bus.w_en) begin
            memD[bus.addr_in] = wrWord;
            for (int i = 0; i < NUM_FAULTS; i++) begin
                if (cfAggrHit[i] && (wrWord[aggrBit[i]] != oldWord[aggrBit[i]])) begin
                    memD[victimAddr[i]][victimBit[i]] = ~memD[victimAddr[i]][victimBit[i]];
                    anyFlip = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rdMasked = (oldWord | sa1All) & ~sa0All;
        if (bus.w_en) begin
            readD_d = memD[bus.addr_in];
            hitNow  = (wrWord != bus.dat_in) || anyFlip;
        end else begin
            readD_d = rdMasked;
            hitNow  = (rdMasked != oldWord);
        end

        faultHits_d = faultHits_q;
        if (hitNow && (faultHits_q != {HIT_W{1'b1}})) begin
            faultHits_d = faultHits_q + HIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            readD_q     <= '0;
            faultHits_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= memD[i];
            end
            readD_q     <= readD_d;
            faultHits_q <= faultHits_d;
        end
    end

    assign bus.read_d     = readD_q;
    assign bus.fault_hits = faultHits_q;

endmodule

// File: tb/tb_sram_fault_model.sv
// Directed scoreboard bench for the SRAM fault model: each access pushes its expected
// read_d / fault_hits and the pair is popped and compared once the registered output appears.
module tb_sram_fault_model;

    localparam logic [2:0] T_SA0   = 3'd0;
    localparam logic [2:0] T_SA1   = 3'd1;
    localparam logic [2:0] T_TFUP  = 3'd2;
    localparam logic [2:0] T_TFDN  = 3'd3;
    localparam logic [2:0] T_CFINV = 3'd4;
    localparam logic [2:0] T_RSV5  = 3'd5;

    typedef struct {
        logic       en;
        logic [2:0] ftype;
        logic [7:0] faddr;
        logic [1:0] fbit;
        logic [7:0] aaddr;
        logic [1:0] abit;
    } tbCfg_t;

    typedef struct {
        string       tag;
        logic [3:0]  rd;
        logic [15:0] hits;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   expHits;
    exp_t expQ[$];

    sram_fault_model_if bus();

    sram_fault_model dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic tbCfg_t mkCfg(input logic en, input logic [2:0] t, input logic [7:0] fa,
                                     input logic [1:0] fb, input logic [7:0] aa, input logic [1:0] ab);
        tbCfg_t c;
        c.en = en; c.ftype = t; c.faddr = fa; c.fbit = fb; c.aaddr = aa; c.abit = ab;
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic wen, input logic [7:0] addr,
                                 input logic [3:0] dat, input logic ld, input logic [1:0] idx,
                                 input tbCfg_t c, input int hitInc, input logic [3:0] expRd);
        exp_t e;
        @(negedge clk);
        bus.w_en       = wen;
        bus.addr_in    = addr;
        bus.dat_in     = dat;
        bus.fault_load = ld;
        bus.fault_idx  = idx;
        bus.fault_en   = c.en;
        bus.fault_type = c.ftype;
        bus.fault_addr = c.faddr;
        bus.fault_bit  = c.fbit;
        bus.aggr_addr  = c.aaddr;
        bus.aggr_bit   = c.abit;
        expHits        = expHits + hitInc;
        e.tag  = tag;
        e.rd   = expRd;
        e.hits = 16'(expHits);
        expQ.push_back(e);
        @(posedge clk);
        #1;
        bus.fault_load = 1'b0;
        bus.w_en       = 1'b0;
        e = expQ.pop_front();
        checkOutput({e.tag, "_rd"}, 32'(bus.read_d), 32'(e.rd));
        checkOutput({e.tag, "_hits"}, 32'(bus.fault_hits), 32'(e.hits));
    endtask

    task automatic doWrite(input string tag, input logic [7:0] addr, input logic [3:0] dat,
                           input int hitInc, input logic [3:0] expRd);
        applyStimulus(tag, 1'b1, addr, dat, 1'b0, 2'd0, mkCfg(0, 0, 0, 0, 0, 0), hitInc, expRd);
    endtask

    task automatic doRead(input string tag, input logic [7:0] addr, input int hitInc,
                          input logic [3:0] expRd);
        applyStimulus(tag, 1'b0, addr, 4'h0, 1'b0, 2'd0, mkCfg(0, 0, 0, 0, 0, 0), hitInc, expRd);
    endtask

    // Load cycles read word 0x00, which is never written and carries no fault.
    task automatic doLoad(input string tag, input logic [1:0] idx, input tbCfg_t c);
        applyStimulus(tag, 1'b0, 8'h00, 4'h0, 1'b1, idx, c, 0, 4'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        expHits = 0;
        rst            = 1'b1;
        bus.w_en       = 1'b0;
        bus.addr_in    = '0;
        bus.dat_in     = '0;
        bus.fault_load = 1'b0;
        bus.fault_idx  = '0;
        bus.fault_en   = 1'b0;
        bus.fault_type = '0;
        bus.fault_addr = '0;
        bus.fault_bit  = '0;
        bus.aggr_addr  = '0;
        bus.aggr_bit   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rd", 32'(bus.read_d), 32'h0);
        checkOutput("reset_hits", 32'(bus.fault_hits), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        doWrite("plainWr", 8'h10, 4'hA, 0, 4'hA);
        doRead ("plainRd", 8'h10, 0, 4'hA);

        doLoad ("ldSa1", 2'd0, mkCfg(1, T_SA1, 8'h05, 2'd2, 8'h00, 2'd0));
        doWrite("sa1Wr", 8'h05, 4'h0, 1, 4'h4);
        doRead ("sa1Rd", 8'h05, 0, 4'h4);
        doWrite("sa0PreWr", 8'h06, 4'h1, 0, 4'h1);
        doLoad ("ldSa0", 2'd1, mkCfg(1, T_SA0, 8'h06, 2'd0, 8'h00, 2'd0));
        doRead ("sa0Rd", 8'h06, 1, 4'h0);

        doLoad ("ldTfUp", 2'd2, mkCfg(1, T_TFUP, 8'h20, 2'd0, 8'h00, 2'd0));
        doWrite("tfUpWr0", 8'h20, 4'h0, 0, 4'h0);
        doWrite("tfUpWrF", 8'h20, 4'hF, 1, 4'hE);
        doRead ("tfUpRd", 8'h20, 0, 4'hE);
        doLoad ("ldTfDn", 2'd3, mkCfg(1, T_TFDN, 8'h21, 2'd3, 8'h00, 2'd0));
        doWrite("tfDnWrF", 8'h21, 4'hF, 0, 4'hF);
        doWrite("tfDnWr0", 8'h21, 4'h0, 1, 4'h8);
        doRead ("tfDnRd", 8'h21, 0, 4'h8);

        doLoad ("ldCf", 2'd2, mkCfg(1, T_CFINV, 8'h31, 2'd0, 8'h30, 2'd1));
        doWrite("cfVicWr", 8'h31, 4'h0, 0, 4'h0);
        doWrite("cfAggWr", 8'h30, 4'h2, 1, 4'h2);
        doRead ("cfVicRd", 8'h31, 0, 4'h1);
        doWrite("cfAggRewr", 8'h30, 4'h2, 0, 4'h2);
        doRead ("cfVicRd2", 8'h31, 0, 4'h1);
        doLoad ("ldCfSelf", 2'd3, mkCfg(1, T_CFINV, 8'h40, 2'd1, 8'h40, 2'd0));
        doWrite("cfSelfWr", 8'h40, 4'h1, 0, 4'h1);

        applyStimulus("sameCycLd", 1'b1, 8'h50, 4'hF, 1'b1, 2'd1,
                      mkCfg(1, T_SA0, 8'h50, 2'd3, 8'h00, 2'd0), 0, 4'hF);
        doRead ("sameCycRd", 8'h50, 1, 4'h7);

        doLoad ("ldRsv", 2'd0, mkCfg(1, T_RSV5, 8'h60, 2'd0, 8'h00, 2'd0));
        doWrite("rsvWr", 8'h60, 4'h0, 0, 4'h0);
        doRead ("rsvRd", 8'h60, 0, 4'h0);
        doRead ("sa1GoneRd", 8'h05, 0, 4'h4);
        doLoad ("ldDis", 2'd1, mkCfg(0, T_SA0, 8'h50, 2'd3, 8'h00, 2'd0));
        doRead ("disRd", 8'h50, 0, 4'hF);
        doLoad ("ldSa0Again", 2'd1, mkCfg(1, T_SA0, 8'h50, 2'd3, 8'h00, 2'd0));
        doWrite("wrapWr", 8'hFF, 4'h9, 0, 4'h9);
        doRead ("wrapRd", 8'hFF, 0, 4'h9);

        @(negedge clk);
        rst         = 1'b1;
        bus.w_en    = 1'b1;
        bus.addr_in = 8'h50;
        bus.dat_in  = 4'h3;
        @(posedge clk);
        #1;
        checkOutput("rstMid_rd", 32'(bus.read_d), 32'h0);
        checkOutput("rstMid_hits", 32'(bus.fault_hits), 32'h0);
        @(negedge clk);
        rst      = 1'b0;
        bus.w_en = 1'b0;
        expHits  = 0;
        doWrite("postRstWr", 8'h50, 4'hF, 0, 4'hF);
        doRead ("postRstRd", 8'h50, 0, 4'hF);
        doRead ("postRstCf", 8'h31, 0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
